// File: rtl/lcd_frame_drv.sv
// KS0108-style 128x64 panel driver: powers up, blanks the right chip, then streams
// 64x64 bitmap column bytes from the producer into the left chip, page by page.
module lcd_frame_drv #(
    parameter logic [15:0] PWR_WAIT = 16'd1000,
    parameter int          EN_CYC   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       en,
    output logic       LCD_rst,
    output logic [1:0] LCD_cs,
    output logic       LCD_rw,
    output logic       LCD_di,
    output logic [7:0] LCD_data,
    output logic       LCD_en,
    output logic       frame_done
);
    typedef enum logic [2:0] {
        S_PWR, S_INIT, S_CLR, S_PAGE, S_COL, S_REQ, S_WAIT, S_WR
    } state_t;

    localparam int            CW       = $clog2(3 * EN_CYC) + 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(3 * EN_CYC - 1);
    localparam logic [CW-1:0] EN_ON    = CW'(EN_CYC);
    localparam logic [CW-1:0] EN_OFF   = CW'(2 * EN_CYC);

    state_t        state_q, state_d;
    logic [15:0]   pwr_q, pwr_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [6:0]    sub_q, sub_d;
    logic [2:0]    clr_pg_q, clr_pg_d;
    logic [8:0]    byte_cnt_q, byte_cnt_d;
    logic [7:0]    pix_q, pix_d;
    logic          bus_wr, wr_done;

    assign LCD_rw  = 1'b0;
    assign wr_done = (cyc_q == CYC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_PWR;
            pwr_q      <= '0;
            cyc_q      <= '0;
            sub_q      <= '0;
            clr_pg_q   <= '0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pwr_q      <= pwr_d;
            cyc_q      <= cyc_d;
            sub_q      <= sub_d;
            clr_pg_q   <= clr_pg_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        pix_q <= pix_d;
    end

    always_comb begin
        state_d    = state_q;
        pwr_d      = pwr_q;
        sub_d      = sub_q;
        clr_pg_d   = clr_pg_q;
        byte_cnt_d = byte_cnt_q;
        pix_d      = pix_q;
        bus_wr     = 1'b0;
        en         = 1'b0;
        frame_done = 1'b0;
        LCD_rst    = 1'b1;
        LCD_cs     = 2'b01;
        LCD_di     = 1'b0;
        LCD_data   = 8'h00;

        case (state_q)
            S_PWR: begin
                LCD_rst = 1'b0;
                LCD_cs  = 2'b00;
                if (pwr_q == PWR_WAIT - 16'd1) begin
                    pwr_d   = '0;
                    state_d = S_INIT;
                end else begin
                    pwr_d = pwr_q + 16'd1;
                end
            end
            S_INIT: begin
                bus_wr   = 1'b1;
                LCD_cs   = 2'b11;
                LCD_data = sub_q[0] ? 8'hC0 : 8'h3F;
                if (wr_done) begin
                    sub_d = sub_q[0] ? 7'd0 : 7'd1;
                    if (sub_q[0]) state_d = S_CLR;
                end
            end
            S_CLR: begin
                // step 0: page address, step 1: column 0, steps 2..65: blank bytes
                bus_wr = 1'b1;
                LCD_cs = 2'b10;
                if (sub_q == 7'd0) begin
                    LCD_data = {5'b10111, clr_pg_q};
                end else if (sub_q == 7'd1) begin
                    LCD_data = 8'h40;
                end else begin
                    LCD_di = 1'b1;
                end
                if (wr_done) begin
                    if (sub_q == 7'd65) begin
                        sub_d    = '0;
                        clr_pg_d = clr_pg_q + 3'd1;
                        if (clr_pg_q == 3'd7) state_d = S_PAGE;
                    end else begin
                        sub_d = sub_q + 7'd1;
                    end
                end
            end
            S_PAGE: begin
                bus_wr   = 1'b1;
                LCD_data = {5'b10111, byte_cnt_q[8:6]};
                if (wr_done) state_d = S_COL;
            end
            S_COL: begin
                bus_wr   = 1'b1;
                LCD_data = 8'h40;
                if (wr_done) state_d = S_REQ;
            end
            S_REQ: begin
                en      = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (data_valid) begin
                    pix_d   = data_in;
                    state_d = S_WR;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WR: begin
                // panel D0 is the top row, the producer puts the top row in the MSB
                bus_wr = 1'b1;
                LCD_di = 1'b1;
                for (int i = 0; i < 8; i++) LCD_data[i] = pix_q[7-i];
                if (wr_done) begin
                    byte_cnt_d = byte_cnt_q + 9'd1;
                    frame_done = (byte_cnt_q == 9'd511);
                    state_d    = (byte_cnt_q[5:0] == 6'd63) ? S_PAGE : S_REQ;
                end
            end
            default: state_d = S_PWR;
        endcase

        cyc_d  = (bus_wr && !wr_done) ? cyc_q + 1'b1 : '0;
        LCD_en = bus_wr && (cyc_q >= EN_ON) && (cyc_q < EN_OFF);
    end
endmodule

// File: tb/tb_lcd_frame_drv.sv
// Bench for lcd_frame_drv: a producer model answers en pulses with random bytes and
// every panel bus write is compared with a queue built from the panel protocol rules.
module tb_lcd_frame_drv;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       en, LCD_rst, LCD_rw, LCD_di, LCD_en, frame_done;
    logic [1:0] LCD_cs;
    logic [7:0] LCD_data;

    int checks = 0;
    int failures = 0;
    int img_cnt = 0;
    int wr_total = 0, en_pulses = 0, en_dbl = 0, fd_hi = 0, fd_at = -1;
    logic len_prev = 1'b0, en_prev = 1'b0;
    logic [10:0] obs_q[$];
    logic [10:0] exp_q[$];

    lcd_frame_drv #(.PWR_WAIT(16'd4), .EN_CYC(1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .en(en), .LCD_rst(LCD_rst), .LCD_cs(LCD_cs), .LCD_rw(LCD_rw),
        .LCD_di(LCD_di), .LCD_data(LCD_data), .LCD_en(LCD_en), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // each rising LCD_en marks one panel write: record {cs, di, data}
    always @(negedge clk) begin
        len_prev <= LCD_en;
        en_prev  <= en;
        if (LCD_en && !len_prev) begin
            obs_q.push_back({LCD_cs, LCD_di, LCD_data});
            wr_total <= wr_total + 1;
        end
        if (en && en_prev) en_dbl <= en_dbl + 1;
        if (en && !en_prev) en_pulses <= en_pulses + 1;
        if (frame_done) begin
            fd_hi <= fd_hi + 1;
            fd_at <= wr_total;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        if (img_cnt % 64 == 0) begin
            exp_q.push_back({2'b01, 1'b0, 8'hB8 | 8'((img_cnt / 64) % 8)});
            exp_q.push_back({2'b01, 1'b0, 8'h40});
        end
        exp_q.push_back({2'b01, 1'b1, rev8(b)});
        img_cnt = (img_cnt + 1) % 512;
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic answer(input logic [7:0] b);
        @(posedge clk);
        #1 data_valid = 1'b1;
        data_in = b;
        @(posedge clk);
        #1 data_valid = 1'b0;
        data_in = 8'($urandom);
    endtask

    task automatic feed(input logic [7:0] b);
        bit ok;
        wait_en(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL en_timeout got=no_en exp=en_pulse");
        end else begin
            answer(b);
            model_byte(b);
        end
    endtask

    task automatic test_reset();
        int low;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (en !== 1'b0) begin failures++; $display("FAIL rst_en got=%b exp=0", en); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
        checks++; if (LCD_rst !== 1'b0) begin failures++; $display("FAIL rst_LCD_rst got=%b exp=0", LCD_rst); end
        checks++; if (LCD_cs !== 2'b00) begin failures++; $display("FAIL rst_LCD_cs got=%b exp=00", LCD_cs); end
        checks++; if (LCD_rw !== 1'b0) begin failures++; $display("FAIL rst_LCD_rw got=%b exp=0", LCD_rw); end
        checks++; if (LCD_di !== 1'b0) begin failures++; $display("FAIL rst_LCD_di got=%b exp=0", LCD_di); end
        checks++; if (LCD_data !== 8'h00) begin failures++; $display("FAIL rst_LCD_data got=%h exp=00", LCD_data); end
        checks++; if (LCD_en !== 1'b0) begin failures++; $display("FAIL rst_LCD_en got=%b exp=0", LCD_en); end
        rst = 1'b0;
        low = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (LCD_rst !== 1'b0) break;
            low++;
        end
        checks++;
        if (low != 4) begin failures++; $display("FAIL pwr_wait_cycles got=%0d exp=4", low); end
    endtask

    task automatic test_init_clear();
        logic [10:0] e, o;
        exp_q.push_back({2'b11, 1'b0, 8'h3F});
        exp_q.push_back({2'b11, 1'b0, 8'hC0});
        for (int p = 0; p < 8; p++) begin
            exp_q.push_back({2'b10, 1'b0, 8'hB8 | 8'(p)});
            exp_q.push_back({2'b10, 1'b0, 8'h40});
            for (int c = 0; c < 64; c++) exp_q.push_back({2'b10, 1'b1, 8'h00});
        end
        for (int n = 0; n < 3000 && obs_q.size() < exp_q.size(); n++) @(negedge clk);
        #1;
        checks++;
        if (en_pulses != 0) begin failures++; $display("FAIL en_before_clear_end got=%0d exp=0", en_pulses); end
        checks++;
        if (obs_q.size() < exp_q.size()) begin
            failures++;
            $display("FAIL init_write_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL init_write got=%h exp=%h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_handshake();
        logic [10:0] e, o;
        feed(8'h80);
        feed(8'h01);
        for (int n = 0; n < 100 && obs_q.size() < exp_q.size(); n++) @(negedge clk);
        repeat (6) @(negedge clk);
        checks++;
        if (obs_q.size() != 4) begin failures++; $display("FAIL handshake_write_count got=%0d exp=4", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL handshake_write got=%h exp=%h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_busy_producer();
        logic [10:0] e, o;
        time t_prev, t_now;
        int dbl0;
        bit ok;
        logic [7:0] b;
        dbl0 = en_dbl;
        b = 8'($urandom);
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_en(ok);
            t_now = $time;
            checks++;
            if (!ok) begin failures++; $display("FAIL busy_en_timeout got=no_en exp=en_pulse"); end
            if (k > 0) begin
                checks++;
                if (t_now - t_prev != 20) begin
                    failures++;
                    $display("FAIL busy_repulse_gap got=%0t exp=20", t_now - t_prev);
                end
            end
            t_prev = t_now;
        end
        answer(b);
        model_byte(b);
        for (int n = 0; n < 100 && obs_q.size() < exp_q.size(); n++) @(negedge clk);
        repeat (6) @(negedge clk);
        checks++;
        if (en_dbl != dbl0) begin failures++; $display("FAIL en_consecutive got=%0d exp=0", en_dbl - dbl0); end
        checks++;
        if (obs_q.size() != 1) begin failures++; $display("FAIL busy_write_count got=%0d exp=1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL busy_write got=%h exp=%h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_page_boundary();
        logic [10:0] e, o;
        while (img_cnt != 65) feed(8'($urandom));
        for (int n = 0; n < 100 && obs_q.size() < exp_q.size(); n++) @(negedge clk);
        checks++;
        if (obs_q.size() < exp_q.size()) begin
            failures++;
            $display("FAIL page_write_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL page_write got=%h exp=%h", o, e); end
        end
        exp_q.delete();
    endtask

    task automatic test_frame_wrap();
        logic [10:0] e, o;
        int fd0;
        fd0 = fd_hi;
        while (img_cnt != 0) feed(8'($urandom));
        for (int n = 0; n < 100 && obs_q.size() < exp_q.size(); n++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (fd_hi - fd0 != 1) begin failures++; $display("FAIL frame_done_cycles got=%0d exp=1", fd_hi - fd0); end
        checks++;
        if (fd_at != 530 + 512 + 16) begin failures++; $display("FAIL frame_done_position got=%0d exp=%0d", fd_at, 530 + 512 + 16); end
        feed(8'($urandom));
        for (int n = 0; n < 100 && obs_q.size() < exp_q.size(); n++) @(negedge clk);
        checks++;
        if (obs_q.size() < exp_q.size()) begin
            failures++;
            $display("FAIL frame_write_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin failures++; $display("FAIL frame_write got=%h exp=%h", o, e); end
        end
        exp_q.delete();
        checks++;
        if (fd_hi - fd0 != 1) begin failures++; $display("FAIL frame_done_extra got=%0d exp=1", fd_hi - fd0); end
    endtask

    task automatic test_reset_mid_write();
        bit ok, seen;
        int low;
        wait_en(ok);
        if (ok) answer(8'h5A);
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (LCD_en) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL mid_LCD_en_timeout got=0 exp=1"); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (LCD_en !== 1'b0) begin failures++; $display("FAIL mid_LCD_en got=%b exp=0", LCD_en); end
        checks++; if (LCD_rst !== 1'b0) begin failures++; $display("FAIL mid_LCD_rst got=%b exp=0", LCD_rst); end
        checks++; if (en !== 1'b0) begin failures++; $display("FAIL mid_en got=%b exp=0", en); end
        checks++; if (LCD_cs !== 2'b00) begin failures++; $display("FAIL mid_LCD_cs got=%b exp=00", LCD_cs); end
        @(posedge clk);
        #1 rst = 1'b0;
        obs_q.delete();
        img_cnt = 0;
        low = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (LCD_rst !== 1'b0) break;
            low++;
        end
        checks++;
        if (low != 4) begin failures++; $display("FAIL mid_pwr_wait got=%0d exp=4", low); end
        for (int n = 0; n < 50 && obs_q.size() < 2; n++) @(negedge clk);
        checks++;
        if (obs_q.size() < 2) begin
            failures++;
            $display("FAIL mid_restart_writes got=%0d exp=2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== {2'b11, 1'b0, 8'h3F}) begin failures++; $display("FAIL mid_restart_cmd0 got=%h exp=%h", obs_q[0], {2'b11, 1'b0, 8'h3F}); end
            checks++;
            if (obs_q[1] !== {2'b11, 1'b0, 8'hC0}) begin failures++; $display("FAIL mid_restart_cmd1 got=%h exp=%h", obs_q[1], {2'b11, 1'b0, 8'hC0}); end
        end
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_handshake();
        test_busy_producer();
        test_page_boundary();
        test_frame_wrap();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
